// File: rtl/ddr4_axi_ctrl_rdwr_arbiter.sv
// ddr4_axi_ctrl_rdwr_arbiter
// AXI4-Lite slave front end for the DDR4 controller control register space.
// AW, W and AR requests are captured in one-deep holding buffers. Pending
// writes and reads are arbitrated round-robin. One register-file access is
// in flight at a time. Unmapped addresses (decoder result 0) get SLVERR.
// Optional feature macro: DDR4_AXI_CTRL_ERR_CNT_EN adds a saturating 8-bit
// SLVERR counter output err_cnt.
module ddr4_axi_ctrl_rdwr_arbiter #(
    parameter int C_ADDR_WIDTH    = 32,
    parameter int C_DATA_WIDTH    = 32,
    parameter int C_NUM_REG_WIDTH = 3
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [C_ADDR_WIDTH-1:0]       s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [C_DATA_WIDTH-1:0]       s_axi_wdata,
    input  logic [C_DATA_WIDTH/8-1:0]     s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0]       s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [C_DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [C_ADDR_WIDTH-1:0]       dec_addr,
    input  logic [C_NUM_REG_WIDTH-1:0]    dec_reg_num,
    output logic [C_NUM_REG_WIDTH-1:0]    reg_num,
    output logic                          reg_wr_en,
    output logic [C_DATA_WIDTH-1:0]       reg_wr_data,
    output logic [C_DATA_WIDTH/8-1:0]     reg_wr_strb,
    output logic                          reg_rd_en,
    input  logic [C_DATA_WIDTH-1:0]       reg_rd_data
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]                    err_cnt
`endif
);

    localparam int C_STRB_WIDTH = C_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ    = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_BRESP   = 3'd4,
        ST_RRESP   = 3'd5
    } state_t;

    state_t                      state_q, state_d;
    logic                        aw_full_q, aw_full_d;
    logic [C_ADDR_WIDTH-1:0]     aw_addr_q, aw_addr_d;
    logic                        w_full_q, w_full_d;
    logic [C_DATA_WIDTH-1:0]     w_data_q, w_data_d;
    logic [C_STRB_WIDTH-1:0]     w_strb_q, w_strb_d;
    logic                        ar_full_q, ar_full_d;
    logic [C_ADDR_WIDTH-1:0]     ar_addr_q, ar_addr_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic                        arready_q, arready_d;
    // 1 = last grant went to a write, 0 = last grant went to a read
    logic                        last_wr_q, last_wr_d;
    logic                        bvalid_q, bvalid_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        rvalid_q, rvalid_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic [C_DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                        rd_hit_q, rd_hit_d;
    logic                        dec_hit_s;
    logic                        wr_pend_s;
    logic                        rd_pend_s;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
    logic [7:0]                  err_cnt_q, err_cnt_d;
    logic                        err_inc_s;
`endif

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_arready = arready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_data   = w_data_q;
    assign reg_wr_strb   = w_strb_q;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
    assign err_cnt       = err_cnt_q;
`endif

    // Decoder address mux and register-file strobes for the access in flight
    always_comb begin
        dec_addr  = aw_addr_q;
        reg_num   = {C_NUM_REG_WIDTH{1'b0}};
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        dec_hit_s = (dec_reg_num != {C_NUM_REG_WIDTH{1'b0}});
        wr_pend_s = aw_full_q & w_full_q;
        rd_pend_s = ar_full_q;
        if (state_q == ST_READ) begin
            dec_addr  = ar_addr_q;
            reg_num   = dec_reg_num;
            reg_rd_en = dec_hit_s;
        end else if (state_q == ST_WRITE) begin
            reg_num   = dec_reg_num;
            reg_wr_en = dec_hit_s;
        end else begin
            reg_num   = {C_NUM_REG_WIDTH{1'b0}};
        end
    end

    // Next-state logic: holding buffers, arbitration and response sequencing
    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        ar_full_d = ar_full_q;
        ar_addr_d = ar_addr_q;
        last_wr_d = last_wr_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_hit_d  = rd_hit_q;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
        err_inc_s = 1'b0;
        err_cnt_d = err_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (wr_pend_s && rd_pend_s) begin
                    if (last_wr_q) begin
                        state_d   = ST_READ;
                        last_wr_d = 1'b0;
                    end else begin
                        state_d   = ST_WRITE;
                        last_wr_d = 1'b1;
                    end
                end else if (wr_pend_s) begin
                    state_d   = ST_WRITE;
                    last_wr_d = 1'b1;
                end else if (rd_pend_s) begin
                    state_d   = ST_READ;
                    last_wr_d = 1'b0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                aw_full_d = 1'b0;
                w_full_d  = 1'b0;
                bresp_d   = dec_hit_s ? RESP_OKAY : RESP_SLVERR;
                bvalid_d  = 1'b1;
                state_d   = ST_BRESP;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
                err_inc_s = !dec_hit_s;
`endif
            end
            ST_BRESP: begin
                if (s_axi_bready) begin
                    bvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_BRESP;
                end
            end
            ST_READ: begin
                ar_full_d = 1'b0;
                rd_hit_d  = dec_hit_s;
                rresp_d   = dec_hit_s ? RESP_OKAY : RESP_SLVERR;
                rdata_d   = {C_DATA_WIDTH{1'b0}};
                state_d   = ST_RD_WAIT;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
                err_inc_s = !dec_hit_s;
`endif
            end
            ST_RD_WAIT: begin
                if (rd_hit_q) begin
                    rdata_d = reg_rd_data;
                end else begin
                    rdata_d = {C_DATA_WIDTH{1'b0}};
                end
                rvalid_d = 1'b1;
                state_d  = ST_RRESP;
            end
            ST_RRESP: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    state_d  = ST_RRESP;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bvalid_d = 1'b0;
                rvalid_d = 1'b0;
            end
        endcase

        // Buffers load after any grant-clear above; a full buffer is never ready
        if (s_axi_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end else begin
            aw_full_d = aw_full_d;
        end
        if (s_axi_wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end else begin
            w_full_d = w_full_d;
        end
        if (s_axi_arvalid && arready_q) begin
            ar_full_d = 1'b1;
            ar_addr_d = s_axi_araddr;
        end else begin
            ar_full_d = ar_full_d;
        end

        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;

`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
        if (err_inc_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
`endif
    end

    // State and output registers; reset drops any transaction in progress
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            aw_full_q <= 1'b0;
            aw_addr_q <= {C_ADDR_WIDTH{1'b0}};
            w_full_q  <= 1'b0;
            w_data_q  <= {C_DATA_WIDTH{1'b0}};
            w_strb_q  <= {C_STRB_WIDTH{1'b0}};
            ar_full_q <= 1'b0;
            ar_addr_q <= {C_ADDR_WIDTH{1'b0}};
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            last_wr_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= {C_DATA_WIDTH{1'b0}};
            rd_hit_q  <= 1'b0;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
            err_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            ar_full_q <= ar_full_d;
            ar_addr_q <= ar_addr_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            last_wr_q <= last_wr_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            rd_hit_q  <= rd_hit_d;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr4_axi_ctrl_rdwr_arbiter.sv
// Self-checking bench for ddr4_axi_ctrl_rdwr_arbiter: scoreboard queues hold
// expected register strobes, grant order and B/R responses; a negedge monitor
// pops and compares them as the DUT produces them.
module tb_ddr4_axi_ctrl_rdwr_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] dec_addr;
    logic [2:0]  dec_reg_num;
    logic [2:0]  reg_num;
    logic        reg_wr_en;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_wr_strb;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data;
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_order[$];
    logic [63:0] exp_w[$];
    logic [63:0] exp_rd[$];
    logic [63:0] exp_b[$];
    logic [63:0] exp_r[$];
    logic [63:0] mon_e;
    logic [31:0] regs [8];

    ddr4_axi_ctrl_rdwr_arbiter dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .dec_addr      (dec_addr),
        .dec_reg_num   (dec_reg_num),
        .reg_num       (reg_num),
        .reg_wr_en     (reg_wr_en),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_strb   (reg_wr_strb),
        .reg_rd_en     (reg_rd_en),
        .reg_rd_data   (reg_rd_data)
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
        ,
        .err_cnt       (err_cnt)
`endif
    );

    // 100 MHz clock
    always #5 aclk = ~aclk;

    // Address decoder stub: word-aligned addresses below 0x20 map to reg addr[4:2]
    always_comb begin
        dec_reg_num = 3'd0;
        if (dec_addr[31:5] == 27'd0 && dec_addr[1:0] == 2'b00) begin
            dec_reg_num = dec_addr[4:2];
        end
    end

    // Register-file stub: byte-strobed writes, read data one cycle after reg_rd_en
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 8; i++) regs[i] <= 32'h0;
            regs[1]     <= 32'h1234_5678;
            regs[3]     <= 32'h1111_1111;
            reg_rd_data <= 32'hBAD0_BAD0;
        end else begin
            if (reg_wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_wr_strb[b]) regs[reg_num][8*b +: 8] <= reg_wr_data[8*b +: 8];
                end
            end
            reg_rd_data <= reg_rd_en ? regs[reg_num] : 32'hBAD0_BAD0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_w(input logic [2:0] num, input logic [31:0] data,
                                           input logic [3:0] strb);
        return {24'h0, strb, 1'b0, num, data};
    endfunction

    // Scoreboard monitor: compare every strobe and response handshake
    always @(negedge aclk) begin
        if (aresetn) begin
            if (reg_wr_en) begin
                mon_e = (exp_order.size() != 0) ? exp_order.pop_front() : 64'h0;
                check_eq("order_wr", 64'h57, mon_e);
                mon_e = (exp_w.size() != 0) ? exp_w.pop_front() : 64'hFFFF;
                check_eq("wr_beat", pack_w(reg_num, reg_wr_data, reg_wr_strb), mon_e);
            end
            if (reg_rd_en) begin
                mon_e = (exp_order.size() != 0) ? exp_order.pop_front() : 64'h0;
                check_eq("order_rd", 64'h52, mon_e);
                mon_e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 64'hFFFF;
                check_eq("rd_num", {61'h0, reg_num}, mon_e);
            end
            if (s_axi_bvalid && s_axi_bready) begin
                mon_e = (exp_b.size() != 0) ? exp_b.pop_front() : 64'hFFFF;
                check_eq("bresp", {62'h0, s_axi_bresp}, mon_e);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                mon_e = (exp_r.size() != 0) ? exp_r.pop_front() : 64'hFFFF_FFFF_FFFF;
                check_eq("rresp_rdata", {30'h0, s_axi_rresp, s_axi_rdata}, mon_e);
            end
        end
    end

    task automatic exp_write(input logic [2:0] num, input logic [31:0] data, input logic [3:0] strb);
        exp_order.push_back(64'h57);
        exp_w.push_back(pack_w(num, data, strb));
        exp_b.push_back(64'h0);
    endtask

    task automatic exp_read(input logic [2:0] num, input logic [31:0] data);
        exp_order.push_back(64'h52);
        exp_rd.push_back({61'h0, num});
        exp_r.push_back({32'h0, data});
    endtask

    task automatic send_aw(input logic [31:0] addr);
        logic hs = 1'b0;
        int   n  = 0;
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge aclk) hs = s_axi_awready;
            @(posedge aclk);
            n++;
        end
        #1 s_axi_awvalid = 1'b0;
        check_eq("aw_hs", {63'h0, hs}, 64'h1);
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        logic hs = 1'b0;
        int   n  = 0;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge aclk) hs = s_axi_wready;
            @(posedge aclk);
            n++;
        end
        #1 s_axi_wvalid = 1'b0;
        check_eq("w_hs", {63'h0, hs}, 64'h1);
    endtask

    task automatic send_ar(input logic [31:0] addr);
        logic hs = 1'b0;
        int   n  = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge aclk) hs = s_axi_arready;
            @(posedge aclk);
            n++;
        end
        #1 s_axi_arvalid = 1'b0;
        check_eq("ar_hs", {63'h0, hs}, 64'h1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_order.size() + exp_w.size() + exp_rd.size() + exp_b.size() + exp_r.size()) != 0
               && n < 200) begin
            @(negedge aclk);
            n++;
        end
        @(negedge aclk);
        check_eq(tag, {63'h0, (n < 200)}, 64'h1);
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axi_awaddr  = 32'h0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'h0;
        s_axi_wstrb   = 4'h0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = 32'h0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_ready", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h0);
        check_eq("rst_valid", {62'h0, s_axi_bvalid, s_axi_rvalid}, 64'h0);
        check_eq("rst_resp", {30'h0, s_axi_bresp, s_axi_rresp, s_axi_rdata}, 64'h0);
        check_eq("rst_reg", {59'h0, reg_wr_en, reg_rd_en, reg_num}, 64'h0);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("post_rst_ready", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);

        // Contention from reset: write first; a new write arriving during B makes
        // the next contention go to the read
        @(posedge aclk); #1;
        exp_write(3'd2, 32'hA5A5_0001, 4'hF);
        exp_read(3'd1, 32'h1234_5678);
        exp_write(3'd4, 32'h0000_BEEF, 4'hF);
        fork
            send_aw(32'h08);
            send_w(32'hA5A5_0001, 4'hF);
            send_ar(32'h04);
        join
        fork
            send_aw(32'h10);
            send_w(32'h0000_BEEF, 4'hF);
        join
        drain("alt_drain");

        // Same-cycle AW+W write with latency checks
        @(posedge aclk); #1;
        exp_write(3'd2, 32'hDEAD_BEEF, 4'hF);
        fork
            send_aw(32'h08);
            send_w(32'hDEAD_BEEF, 4'hF);
        join
        @(negedge aclk);
        check_eq("wr_lat_n0", {62'h0, reg_wr_en, s_axi_bvalid}, 64'h0);
        @(negedge aclk);
        check_eq("wr_lat_n1", {60'h0, reg_wr_en, reg_num}, 64'hA);
        @(negedge aclk);
        check_eq("wr_lat_n2", {61'h0, s_axi_bvalid, s_axi_bresp}, 64'h4);
        drain("wr_drain");

        // Mapped read with latency checks
        @(posedge aclk); #1;
        exp_read(3'd1, 32'h1234_5678);
        send_ar(32'h04);
        @(negedge aclk);
        @(negedge aclk);
        check_eq("rd_lat_n1", {60'h0, reg_rd_en, reg_num}, 64'h9);
        @(negedge aclk);
        check_eq("rd_lat_n2", {63'h0, s_axi_rvalid}, 64'h0);
        @(negedge aclk);
        check_eq("rd_lat_n3", {63'h0, s_axi_rvalid}, 64'h1);
        drain("rd_drain");

        // Unmapped read: SLVERR, zero data, no strobe
        @(posedge aclk); #1;
        exp_r.push_back({30'h0, 2'b10, 32'h0});
        send_ar(32'h100);
        drain("rd_err_drain");
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
        check_eq("err_cnt_1", {56'h0, err_cnt}, 64'h1);
`endif

        // Unmapped write (decoder result 0 at address 0): SLVERR, no strobe
        @(posedge aclk); #1;
        exp_b.push_back(64'h2);
        fork
            send_aw(32'h00);
            send_w(32'hFFFF_FFFF, 4'hF);
        join
        drain("wr_err_drain");
`ifdef DDR4_AXI_CTRL_ERR_CNT_EN
        check_eq("err_cnt_2", {56'h0, err_cnt}, 64'h2);
`endif

        // Partial-strobe write then read back through the register stub
        @(posedge aclk); #1;
        exp_write(3'd3, 32'hAABB_CCDD, 4'b0011);
        fork
            send_aw(32'h0C);
            send_w(32'hAABB_CCDD, 4'b0011);
        join
        drain("strb_wr_drain");
        @(posedge aclk); #1;
        exp_read(3'd3, 32'h1111_CCDD);
        send_ar(32'h0C);
        drain("strb_rd_drain");

        // W well before AW, B stalled for 10+ cycles, AR accepted during the stall
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
        exp_write(3'd5, 32'h5555_AAAA, 4'hF);
        exp_read(3'd1, 32'h1234_5678);
        send_w(32'h5555_AAAA, 4'hF);
        @(negedge aclk);
        check_eq("wready_drop", {63'h0, s_axi_wready}, 64'h0);
        repeat (4) @(posedge aclk);
        #1;
        send_aw(32'h14);
        begin
            int n = 0;
            while (!s_axi_bvalid && n < 50) begin
                @(negedge aclk);
                n++;
            end
            check_eq("b_wait", {63'h0, (n < 50)}, 64'h1);
        end
        @(posedge aclk); #1;
        send_ar(32'h04);
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check_eq("b_stall", {60'h0, s_axi_bvalid, reg_rd_en, s_axi_bresp}, 64'h8);
        end
        @(posedge aclk); #1;
        s_axi_bready = 1'b1;
        drain("stall_drain");

        // Async reset while a read response is stalled
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
        exp_read(3'd1, 32'h1234_5678);
        send_ar(32'h04);
        begin
            int n = 0;
            while (!s_axi_rvalid && n < 50) begin
                @(negedge aclk);
                n++;
            end
            check_eq("r_wait", {63'h0, (n < 50)}, 64'h1);
        end
        @(posedge aclk); #2;
        aresetn = 1'b0;
        #1;
        check_eq("async_rvalid", {63'h0, s_axi_rvalid}, 64'h0);
        exp_r.delete();
        s_axi_rready = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_eq("rerst_ready", {61'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 64'h7);
        check_eq("rerst_valid", {62'h0, s_axi_bvalid, s_axi_rvalid}, 64'h0);
        @(posedge aclk); #1;
        exp_read(3'd1, 32'h1234_5678);
        send_ar(32'h04);
        drain("rerst_drain");

        check_eq("queues_empty",
                 64'(exp_order.size() + exp_w.size() + exp_rd.size() + exp_b.size() + exp_r.size()),
                 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
